cp0_int_ctrl: RTL
=================

// Module: cp0_int_ctrl
// PURPOSE
//  Coprocessor-0 exception/interrupt controller. It sits downstream of the timer and other
//  bridge devices: their IRQ lines arrive on HWInt, are latched into Cause.IP and masked by
//  SR.IM/IE/EXL, and merge with synchronous exceptions from the pipeline into one take signal.
//  It also holds the SR/Cause/EPC/PRId registers that mfc0/mtc0/eret access.
// PARAMETERS
//  PRID     32'h4C57_0001  value returned by PRId (reg 15), read-only
//  HWINT_W  6              hardware interrupt lines, mapped to Cause.IP/SR.IM bits [15:10]
// PORTS
//  Clk      in   1        system clock, rising edge
//  Reset    in   1        asynchronous, active-high; clears all state
//  RdSel    in   5        mfc0 register number
//  WrSel    in   5        mtc0 register number
//  We       in   1        mtc0 write enable
//  Din      in   32       mtc0 write data
//  PCIn     in   32       PC of the instruction at the commit point
//  BDIn     in   1        commit instruction is in a branch delay slot
//  ExcReq   in   1        synchronous exception request from the pipeline
//  ExcCode  in   5        cause code for ExcReq
//  EXLClr   in   1        eret at commit
//  HWInt    in   HWINT_W  device interrupt lines (timer IRQ on bit 0)
//  Dout     out  32       mfc0 read data (combinational)
//  EPC      out  32       current EPC, target for eret
//  ExcTake  out  1        exception/interrupt taken this cycle; pipeline flushes, vectors to handler
// BEHAVIOUR
//  Reset (async): SR=0, Cause=0, EPC=0. Outputs: ExcTake=0, EPC=0, Dout=0 for regs 12-14.
//  Registers:
//   - SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}. Other bits are written-ignored and read 0.
//   - Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}. Not software-writable.
//   - EPC(14) holds 32 bits with [1:0] forced to 0.
//   - PRId(15) = PRID.
//   - Any other RdSel reads 0.
//  Dout: pure mux on RdSel; it reflects register state, not same-cycle writes.
//  Cause.IP: IP <= HWInt every posedge, unconditionally. HWInt-to-IP latency is 1 cycle.
//  Interrupt request: IntReq = IE & ~EXL & |(IP & IM), combinational from registers.
//   - A timer IRQ rise at edge N gives IntReq high after edge N+1.
//  ExcTake = IntReq | (ExcReq & ~EXL). An ExcReq while EXL=1 is dropped; no state changes.
//  On posedge with ExcTake=1:
//   - EXL<=1.
//   - ExcCode <= IntReq ? 5'd0 : ExcCode. Interrupt has priority over a simultaneous ExcReq.
//   - BD<=BDIn.
//   - EPC <= BDIn ? PCIn-4 : PCIn, with [1:0] cleared. Arithmetic is mod 2^32, so PCIn=0 with BDIn=1 gives 32'hFFFF_FFFC.
//   - IE and IM are unchanged.
//  On posedge with EXLClr=1 and ExcTake=0: EXL<=0.
//  mtc0 (We=1):
//   - WrSel=12 updates IM, EXL, IE from Din.
//   - WrSel=14 updates EPC.
//   - WrSel=13, 15 and others are ignored.
//  Priority per field, same edge: ExcTake > EXLClr > mtc0.
//   - Example: mtc0 EPC coinciding with ExcTake leaves EPC = the exception value.
//   - Example: mtc0 SR coinciding with EXLClr still updates IM/IE, but EXL ends 0.
//  Reset mid-operation: state clears immediately. ExcTake drops in the same cycle, without waiting for a clock edge.
//  No internal FSM beyond EXL; interrupts nest only if software clears EXL.
// TESTING
//  1. Reset, then mtc0 SR=32'h0000_FC01, hold HWInt=6'b000001 -> IntReq/ExcTake rise 1 cycle later.
//     At the next edge: EXL=1, Cause=32'h0000_0400, EPC=PCIn.
//  2. With EXL=1, pulse ExcReq with ExcCode=5'd10 -> ExcTake stays 0; Cause and EPC are unchanged.
//     Then pulse EXLClr -> EXL=0, and the still-pending HWInt retriggers ExcTake.
//  3. EXL=0, IE=1, IM=0, ExcReq with ExcCode=5'd4, BDIn=1, PCIn=32'h0000_3008 -> EPC=32'h0000_3004.
//     Cause=32'h8000_0010.
//     Repeat with PCIn=0, BDIn=1 -> EPC=32'hFFFF_FFFC.
//  4. Same cycle: IntReq=1, ExcReq=1 with ExcCode=12, We=1, WrSel=14, Din=32'h1234 -> ExcCode=0 (interrupt wins).
//     EPC=PCIn, not 32'h1234.
//  5. mtc0 SR with Din=32'hFFFF_FFFF -> SR reads 32'h0000_FC03.
//     mtc0 Cause is ignored. RdSel=15 -> PRID. RdSel=7 -> 0.
//  6. Assert Reset between clock edges while ExcTake=1 -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 exception/interrupt controller: holds SR/Cause/EPC/PRId and merges
// latched device interrupts with synchronous pipeline exceptions into one take signal.
module cp0_int_ctrl #(
    parameter logic [31:0] PRID    = 32'h4C57_0001,
    parameter int          HWINT_W = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [4:0]         RdSel,
    input  logic [4:0]         WrSel,
    input  logic               We,
    input  logic [31:0]        Din,
    input  logic [31:0]        PCIn,
    input  logic               BDIn,
    input  logic               ExcReq,
    input  logic [4:0]         ExcCode,
    input  logic               EXLClr,
    input  logic [HWINT_W-1:0] HWInt,
    output logic [31:0]        Dout,
    output logic [31:0]        EPC,
    output logic               ExcTake
);

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;

    logic [HWINT_W-1:0] sr_im;
    logic               sr_exl;
    logic               sr_ie;
    logic               cause_bd;
    logic [HWINT_W-1:0] cause_ip;
    logic [4:0]         cause_code;
    logic [31:0]        epc_q;

    logic               int_req;
    logic [31:0]        sr_val;
    logic [31:0]        cause_val;
    logic [31:0]        epc_exc;

    // Interrupts are only recognised outside the handler, with the global enable set.
    assign int_req = sr_ie & ~sr_exl & (|(cause_ip & sr_im));

    // Gated by Reset so the flush request vanishes immediately, not at the next edge.
    assign ExcTake = ~Reset & (int_req | (ExcReq & ~sr_exl));

    assign EPC = epc_q;

    always_comb begin
        sr_val                   = '0;
        sr_val[10 +: HWINT_W]    = sr_im;
        sr_val[1]                = sr_exl;
        sr_val[0]                = sr_ie;

        cause_val                = '0;
        cause_val[31]            = cause_bd;
        cause_val[10 +: HWINT_W] = cause_ip;
        cause_val[6:2]           = cause_code;

        // A delay-slot instruction restarts at its branch, one word earlier.
        epc_exc = (BDIn ? (PCIn - 32'd4) : PCIn) & 32'hFFFF_FFFC;
    end

    always_comb begin
        Dout = '0;
        case (RdSel)
            SEL_SR:    Dout = sr_val;
            SEL_CAUSE: Dout = cause_val;
            SEL_EPC:   Dout = epc_q;
            SEL_PRID:  Dout = PRID;
            default:   Dout = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cause_ip <= '0;
        end else begin
            cause_ip <= HWInt;
        end
    end

    // Per-field priority on each edge: exception entry, then eret, then mtc0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sr_im      <= '0;
            sr_exl     <= 1'b0;
            sr_ie      <= 1'b0;
            cause_bd   <= 1'b0;
            cause_code <= '0;
            epc_q      <= '0;
        end else if (ExcTake) begin
            sr_exl   <= 1'b1;
            cause_bd <= BDIn;
            epc_q    <= epc_exc;
            if (int_req) begin
                cause_code <= 5'd0;
            end else begin
                cause_code <= ExcCode;
            end
        end else begin
            if (We && (WrSel == SEL_SR)) begin
                sr_im <= Din[10 +: HWINT_W];
                sr_ie <= Din[0];
            end
            if (EXLClr) begin
                sr_exl <= 1'b0;
            end else if (We && (WrSel == SEL_SR)) begin
                sr_exl <= Din[1];
            end
            if (We && (WrSel == SEL_EPC)) begin
                epc_q <= Din & 32'hFFFF_FFFC;
            end
        end
    end

endmodule
